// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low keypad scanner with debounce, key strobe and two-digit entry register
module keypad_scan #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] ROW,
  input  logic [3:0] COL,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [7:0] data
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_REL} state_t;
  state_t        state_q, state_d;
  logic [3:0]    col_s1_q, col_s2_q;
  logic [DW-1:0] div_q;
  logic [1:0]    row_q;
  logic [11:0]   samp_q;
  logic          tick;
  logic [15:0]   scan_vec;
  logic [1:0]    ones;
  logic [3:0]    hit_code;
  logic          done_q;
  logic [1:0]    ones_q;
  logic [3:0]    code_q;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    cand_q, cand_d;
  logic          rep;
  logic          key_valid_q;
  logic [3:0]    key_code_q;
  logic [7:0]    data_q;
  assign tick      = div_q == DW'(SCAN_DIV - 1);
  assign ROW       = ~(4'b0001 << row_q);
  assign scan_vec  = {~col_s2_q, samp_q};
  assign cnt_inc   = cnt_q + 1'b1;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign data      = data_q;
  // Two-flop synchroniser on the asynchronous column inputs (idle = all high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
    end else begin
      col_s1_q <= COL;
      col_s2_q <= col_s1_q;
    end
  end
  // Row dwell divider, row pointer and per-row column capture; rows 0..2 shift down so [3:0] ends up as row 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      row_q  <= 2'd0;
      samp_q <= '0;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) begin
        row_q  <= row_q + 2'd1;
        samp_q <= {~col_s2_q, samp_q[11:4]};
      end
    end
  end
  // Classify a full scan: number of pressed keys (saturating at 2) and the code of a pressed key
  always_comb begin
    ones     = 2'd0;
    hit_code = 4'h0;
    for (int i = 0; i < 16; i++)
      if (scan_vec[i]) begin
        hit_code = 4'(i);
        ones     = (ones == 2'd0) ? 2'd1 : 2'd2;
      end
  end
  // Register the scan result as a one-cycle scan_done pulse after the row-3 tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      ones_q <= 2'd0;
      code_q <= 4'h0;
    end else begin
      done_q <= tick && row_q == 2'd3;
      if (tick && row_q == 2'd3) begin
        ones_q <= ones;
        code_q <= hit_code;
      end
    end
  end
  // Debounce FSM state, consecutive-scan counter and candidate key
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end
  // Debounce next-state: act only on scan_done; a report fires when the press count reaches its target
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    rep     = 1'b0;
    if (done_q)
      case (state_q)
        IDLE:
          if (ones_q == 2'd1) begin
            state_d = DEB_PRESS;
            cand_d  = code_q;
            cnt_d   = CW'(1);
          end
        DEB_PRESS:
          if (ones_q == 2'd1 && code_q == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
              state_d = PRESSED;
              rep     = 1'b1;
            end
          end else if (ones_q == 2'd1) begin
            cand_d = code_q;
            cnt_d  = CW'(1);
          end else
            state_d = IDLE;
        PRESSED:
          if (ones_q == 2'd0) begin
            state_d = DEB_REL;
            cnt_d   = CW'(1);
          end
        DEB_REL:
          if (ones_q == 2'd0) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(DEBOUNCE_SCANS)) state_d = IDLE;
          end else
            state_d = PRESSED;
      endcase
  end
  // Registered report: strobe, held code and entry shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      data_q      <= 8'h00;
    end else begin
      key_valid_q <= rep;
      if (rep) begin
        key_code_q <= cand_q;
        data_q     <= {data_q[3:0], cand_q};
      end
    end
  end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed scenario bench for keypad_scan with a modelled 4x4 key matrix
module tb_keypad_scan;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] ROW;
  logic [3:0] col;
  logic       key_valid;
  logic [3:0] key_code;
  logic [7:0] data;
  logic [15:0] held = 16'h0;
  int errors = 0;
  int checks = 0;
  int n;
  int strobes = 0;
  int dbl = 0;
  int last_n = -1;
  logic [3:0] last_code;
  logic [7:0] last_data;
  logic prev_kv = 1'b0;
  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk(clk), .rst_n(rst_n), .ROW(ROW), .COL(col),
    .key_valid(key_valid), .key_code(key_code), .data(data)
  );
  always #5 clk = ~clk;
  // key matrix: a held key at code 4r+c pulls column c low while row r is driven low
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!ROW[r]) col = col & ~held[4*r +: 4];
  end
  // cycle index since reset release; state n holds between posedge n and n+1
  always @(posedge clk or negedge rst_n)
    if (!rst_n) n <= 0;
    else n <= n + 1;
  // strobe monitor
  always @(negedge clk)
    if (rst_n) begin
      if (key_valid) begin
        strobes++;
        last_n = n;
        last_code = key_code;
        last_data = data;
        if (prev_kv) dbl++;
      end
      prev_kv = key_valid;
    end
  task automatic run(input logic [15:0] k, input int s);
    held = k;
    repeat (16 * s) @(negedge clk);
  endtask
  task automatic test_reset;
    logic [3:0] exp_row;
    held = 16'h0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ROW !== 4'b1110) begin errors++; $display("FAIL reset_row: got %b expected 1110", ROW); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_kv: got %b expected 0", key_valid); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_code: got %h expected 0", key_code); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_row = ~(4'b0001 << (i / 4));
      checks++; if (ROW !== exp_row) begin errors++; $display("FAIL row_cycle[%0d]: got %b expected %b", i, ROW, exp_row); end
      @(negedge clk);
    end
    run(16'h0, 2);
    checks++; if (strobes !== 0) begin errors++; $display("FAIL idle_strobes: got %0d expected 0", strobes); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL idle_data: got %h expected 00", data); end
  endtask
  task automatic test_clean;
    int s0 = n / 16;
    int b = strobes;
    run(16'h0200, 3);
    run(16'h0, 2);
    checks++; if (strobes !== b + 1) begin errors++; $display("FAIL clean9_count: got %0d expected %0d", strobes - b, 1); end
    checks++; if (last_n !== 16 * (s0 + 1) + 17) begin errors++; $display("FAIL clean9_time: got %0d expected %0d", last_n, 16 * (s0 + 1) + 17); end
    checks++; if (last_code !== 4'h9) begin errors++; $display("FAIL clean9_code: got %h expected 9", last_code); end
    checks++; if (last_data !== 8'h09) begin errors++; $display("FAIL clean9_data: got %h expected 09", last_data); end
    s0 = n / 16;
    run(16'h0008, 2);
    run(16'h0, 2);
    checks++; if (strobes !== b + 2) begin errors++; $display("FAIL clean3_count: got %0d expected %0d", strobes - b, 2); end
    checks++; if (last_n !== 16 * (s0 + 1) + 17) begin errors++; $display("FAIL clean3_time: got %0d expected %0d", last_n, 16 * (s0 + 1) + 17); end
    checks++; if (key_code !== 4'h3) begin errors++; $display("FAIL clean3_code: got %h expected 3", key_code); end
    checks++; if (data !== 8'h93) begin errors++; $display("FAIL clean3_data: got %h expected 93", data); end
  endtask
  task automatic test_bounce;
    int s0 = n / 16;
    int b = strobes;
    run(16'h0020, 1);
    run(16'h0, 1);
    run(16'h0020, 2);
    run(16'h0, 2);
    checks++; if (strobes !== b + 1) begin errors++; $display("FAIL bounce_count: got %0d expected 1", strobes - b); end
    checks++; if (last_n !== 16 * (s0 + 3) + 17) begin errors++; $display("FAIL bounce_time: got %0d expected %0d", last_n, 16 * (s0 + 3) + 17); end
    checks++; if (last_code !== 4'h5) begin errors++; $display("FAIL bounce_code: got %h expected 5", last_code); end
    checks++; if (data !== 8'h35) begin errors++; $display("FAIL bounce_data: got %h expected 35", data); end
  endtask
  task automatic test_held_change;
    int s0 = n / 16;
    int b = strobes;
    run(16'h0080, 5);
    run(16'h0400, 5);
    checks++; if (strobes !== b + 1) begin errors++; $display("FAIL held_count: got %0d expected 1", strobes - b); end
    checks++; if (last_n !== 16 * (s0 + 1) + 17) begin errors++; $display("FAIL held_time: got %0d expected %0d", last_n, 16 * (s0 + 1) + 17); end
    checks++; if (key_code !== 4'h7) begin errors++; $display("FAIL held_code: got %h expected 7", key_code); end
    checks++; if (data !== 8'h57) begin errors++; $display("FAIL held_data: got %h expected 57", data); end
    run(16'h0, 2);
    s0 = n / 16;
    run(16'h0400, 2);
    run(16'h0, 2);
    checks++; if (strobes !== b + 2) begin errors++; $display("FAIL change_count: got %0d expected 2", strobes - b); end
    checks++; if (last_n !== 16 * (s0 + 1) + 17) begin errors++; $display("FAIL change_time: got %0d expected %0d", last_n, 16 * (s0 + 1) + 17); end
    checks++; if (key_code !== 4'hA) begin errors++; $display("FAIL change_code: got %h expected a", key_code); end
    checks++; if (data !== 8'h7A) begin errors++; $display("FAIL change_data: got %h expected 7a", data); end
  endtask
  task automatic test_multi;
    int s0;
    int b = strobes;
    run(16'h8001, 5);
    checks++; if (strobes !== b) begin errors++; $display("FAIL multi_none: got %0d strobes expected 0", strobes - b); end
    checks++; if (data !== 8'h7A) begin errors++; $display("FAIL multi_data: got %h expected 7a", data); end
    s0 = n / 16;
    run(16'h0001, 2);
    run(16'h0, 2);
    checks++; if (strobes !== b + 1) begin errors++; $display("FAIL multi_single_count: got %0d expected 1", strobes - b); end
    checks++; if (last_n !== 16 * (s0 + 1) + 17) begin errors++; $display("FAIL multi_single_time: got %0d expected %0d", last_n, 16 * (s0 + 1) + 17); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL multi_single_code: got %h expected 0", key_code); end
    checks++; if (data !== 8'hA0) begin errors++; $display("FAIL multi_single_data: got %h expected a0", data); end
  endtask
  task automatic test_reset_mid;
    int b;
    for (int p = 0; p < 2; p++) begin
      if (p == 0) begin
        run(16'h0040, 1);
        repeat (3) @(negedge clk);
      end else
        repeat (2) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++; if (ROW !== 4'b1110) begin errors++; $display("FAIL midrst%0d_row: got %b expected 1110", p, ROW); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL midrst%0d_kv: got %b expected 0", p, key_valid); end
      checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL midrst%0d_code: got %h expected 0", p, key_code); end
      checks++; if (data !== 8'h00) begin errors++; $display("FAIL midrst%0d_data: got %h expected 00", p, data); end
      @(negedge clk);
      rst_n = 1'b1;
      b = strobes;
      run(16'h0040, 3);
      checks++; if (strobes !== b + 1) begin errors++; $display("FAIL midrst%0d_count: got %0d expected 1", p, strobes - b); end
      checks++; if (last_n !== 33) begin errors++; $display("FAIL midrst%0d_time: got %0d expected 33", p, last_n); end
      checks++; if (key_code !== 4'h6) begin errors++; $display("FAIL midrst%0d_code6: got %h expected 6", p, key_code); end
      checks++; if (data !== 8'h06) begin errors++; $display("FAIL midrst%0d_data6: got %h expected 06", p, data); end
    end
    run(16'h0, 2);
  endtask
  task automatic test_back_to_back;
    checks++; if (dbl !== 0) begin errors++; $display("FAIL strobe_width: got %0d double strobes expected 0", dbl); end
  endtask
  initial begin
    test_reset;
    test_clean;
    test_bounce;
    test_held_change;
    test_multi;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans a 4x4 active-low matrix keypad and debounces it. Produces a one-cycle strobe and a hex code for each new key press. Shifts each accepted nibble into an 8-bit entry register whose output feeds the two-digit hex display driver's `data` input. This block is the input side of the front panel, paired with the multiplexed segment display.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each row is driven; must be ≥ 4.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full scans required to accept a press or a release; must be ≥ 2.

Ports:
- `clk` in, 1: system clock, rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `ROW` out, 4: row drive, active-low, exactly one bit low.
- `COL` in, 4: column sense, active-low, externally pulled up, asynchronous.
- `key_valid` out, 1: one-cycle strobe on an accepted press.
- `key_code` out, 4: code of the last accepted key, held between presses.
- `data` out, 8: entry register; the last two accepted codes, newest in `[3:0]`.

## Operation
- **COL synchroniser:** `COL` passes through a 2-FF synchroniser before any use.
- **Divider and row select:**
  - `div_cnt` counts 0..SCAN_DIV-1 and wraps.
  - `tick` = (`div_cnt`==SCAN_DIV-1).
  - `row_idx` (2 bits) advances on `tick` and wraps 3→0.
  - `ROW` = ~(4'b0001 << `row_idx`).
- **Column sampling:** on `tick`, the synchronised columns for the current row are captured before `row_idx` advances.
- **Key code:** row r, column c (bit index) → `{r[1:0], c[1:0]}`. Row 0 / col 0 = 4'h0; row 3 / col 3 = 4'hF.
- **Scan result:** on the `tick` with `row_idx`==3, the 16 sampled bits form one scan. A `scan_done` pulse is registered on the next cycle with this classification:
  - NONE: no low bit.
  - SINGLE(code): exactly one low bit.
  - MULTI: two or more low bits.
- **FSM:** acts only on `scan_done`. `cnt` counts from 1 up to DEBOUNCE_SCANS.
  - IDLE:
    - SINGLE(k) → DEB_PRESS, `cand`=k, `cnt`=1.
    - Otherwise stay.
  - DEB_PRESS:
    - SINGLE(`cand`) → `cnt`+1. If the new `cnt`==DEBOUNCE_SCANS → PRESSED and report.
    - SINGLE(other k) → restart: `cand`=k, `cnt`=1.
    - NONE or MULTI → IDLE.
  - PRESSED:
    - NONE → DEB_REL, `cnt`=1.
    - SINGLE (any code) or MULTI → stay. No new report until release.
  - DEB_REL:
    - NONE → `cnt`+1. If the new `cnt`==DEBOUNCE_SCANS → IDLE.
    - SINGLE or MULTI → PRESSED. No report.
- **Report:** on the next clock after the report decision:
  - `key_valid`=1 for one cycle.
  - `key_code`=`cand`.
  - `data`={`data[3:0]`, `cand`}.
- **Reset:** asserting `rst_n` at any time, including mid-debounce or mid-press, forces the reset state below immediately. After release, scanning restarts at row 0. A key held through reset is reported again after DEBOUNCE_SCANS scans.

## Timing
- **Reset values:**
  - `ROW`=4'b1110, `key_valid`=0, `key_code`=4'h0, `data`=8'h00.
  - FSM in IDLE; `div_cnt`, `row_idx`, `cnt`, `cand` all 0.
- **Scan period:** 4·SCAN_DIV cycles.
- **Input latency:** `COL` → synchronised value takes 2 cycles. A sample on `tick` reflects `COL` at least SCAN_DIV-2 cycles after the row switched, so it has settled.
- **Strobe latency:** `key_valid` rises exactly 2 cycles after the row-3 `tick` that completes the DEBOUNCE_SCANS-th consecutive SINGLE(`cand`) scan: 1 cycle for `scan_done`, 1 for the registered outputs.
- **Minimum press-to-strobe:** DEBOUNCE_SCANS full scans, measured from the first scan that sampled the key in its row.
- **Output registers:** `key_code` and `data` change only in the `key_valid` cycle. `key_valid` is never high two cycles in a row.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_SCANS=2 (scan period 16 cycles).
- **Reset:** reset, then release with `COL`=4'hF. Require `ROW` cycling 1110→1101→1011→0111, each for 4 cycles. Require `key_valid` never asserted, `data`=8'h00.
- **Clean presses:** model the key (row 2, col 1) pulling `COL[1]` low while `ROW[2]` is low, held for 3 scans. Require exactly one `key_valid`, with `key_code`=4'h9 and `data`=8'h09, 2 cycles after the 2nd scan's row-3 tick. Release, then press key 4'h3 (row 0, col 3). Require `data`=8'h93.
- **Bounce:** key 4'h5 present in scan 1, absent in scan 2, present in scans 3–4. Require a single strobe, after scan 4 only.
- **Held / changed key:** hold 4'h7 for 10 scans, switching to 4'hA without any NONE scan in between. Require only one strobe (code 4'h7). After ≥ 2 NONE scans then a 2-scan 4'hA press, require a strobe with `data`=8'h7A.
- **Multi-key:** keys 4'h0 and 4'hF pressed together for 5 scans. Require no strobe. Release 4'hF, keep 4'h0 for 2 scans. Require a strobe with `key_code`=4'h0.
- **Reset mid-operation:** assert `rst_n` low during DEB_PRESS and again during PRESSED. Require all outputs at their reset values within the same cycle. A still-held key strobes again 2 scans after release of reset.
